// File: rtl/sb_regfile_if.sv
// sb_regfile_if
//   Decode/write-back bundle for the scoreboarded register file.
//   master : decode/write-back side (drives the i_* requests, observes the o_* results)
//   slave  : register file (consumes the i_* requests, drives the o_* results)
//   Signals:
//     i_rd_num    NRD*RW    source register numbers, port k at [k*RW +: RW]
//     i_dst_num   RW        destination to reserve
//     i_dst_valid 1         decode instruction writes i_dst_num
//     i_hold      1         external stall, suppresses hazard stall and reservation
//     i_flush     1         drop every reservation
//     i_wb_valid  NWB       per write-back port enable
//     i_wb_num    NWB*RW    per write-back port destination
//     i_wb_data   NWB*XLEN  per write-back port data
//     i_stackptr  XLEN      reset value of the stack pointer register
//     o_rd_data   NRD*XLEN  registered operand data
//     o_stall     1         combinational hazard stall
//     o_busy_cnt  RW+1      registered busy-register count
interface sb_regfile_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWB  = 2
);
  localparam int RW = $clog2(NREG);

  logic [NRD*RW-1:0]   i_rd_num;
  logic [RW-1:0]       i_dst_num;
  logic                i_dst_valid;
  logic                i_hold;
  logic                i_flush;
  logic [NWB-1:0]      i_wb_valid;
  logic [NWB*RW-1:0]   i_wb_num;
  logic [NWB*XLEN-1:0] i_wb_data;
  logic [XLEN-1:0]     i_stackptr;
  logic [NRD*XLEN-1:0] o_rd_data;
  logic                o_stall;
  logic [RW:0]         o_busy_cnt;

  modport master (
    output i_rd_num, i_dst_num, i_dst_valid, i_hold, i_flush,
           i_wb_valid, i_wb_num, i_wb_data, i_stackptr,
    input  o_rd_data, o_stall, o_busy_cnt
  );

  modport slave (
    input  i_rd_num, i_dst_num, i_dst_valid, i_hold, i_flush,
           i_wb_valid, i_wb_num, i_wb_data, i_stackptr,
    output o_rd_data, o_stall, o_busy_cnt
  );
endinterface

// File: rtl/sb_regfile.sv
// sb_regfile
//   Integer register file with a busy scoreboard, NRD registered read ports and
//   NWB write-back ports that bypass into same-cycle reads.
//   Ports:
//     clk    clock, all state changes on the rising edge
//     reset  synchronous active-high reset
//     bus    sb_regfile_if.slave decode/write-back bundle (see interface file)
module sb_regfile #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWB    = 2,
  parameter int SP_IDX = 2
) (
  input logic        clk,
  input logic        reset,
  sb_regfile_if.slave bus
);
  localparam int RW = $clog2(NREG);

  logic [XLEN-1:0] regs_q    [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [RW:0]     busy_cnt_q;
  logic [RW:0]     busy_cnt_d;
  logic [XLEN-1:0] rd_data_q [NRD];
  logic [XLEN-1:0] rd_val    [NRD];
  logic [RW-1:0]   rd_num    [NRD];
  logic [RW-1:0]   wb_num    [NWB];
  logic [XLEN-1:0] wb_data   [NWB];

  // Per-register view of this cycle's effective writes.
  logic [NREG-1:0] wr_hit;
  logic [XLEN-1:0] wr_data   [NREG];
  logic [NREG-1:0] eff_busy;
  logic            hazard;
  logic            stall;
  logic            reserve;

  genvar gi;

  generate
    for (gi = 0; gi < NWB; gi++) begin : g_wb_unpack
      assign wb_num[gi]  = bus.i_wb_num[gi*RW +: RW];
      assign wb_data[gi] = bus.i_wb_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Ports are scanned in ascending order so the highest-index port that hits
  // a register overrides the others. r0 never takes a write.
  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      wr_data[r] = '0;
    end
    for (int w = 0; w < NWB; w++) begin
      if (bus.i_wb_valid[w] && (wb_num[w] != '0)) begin
        wr_hit[wb_num[w]]  = 1'b1;
        wr_data[wb_num[w]] = wb_data[w];
      end
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      assign rd_num[gi] = bus.i_rd_num[gi*RW +: RW];
      assign rd_val[gi] = (rd_num[gi] == '0)  ? '0 :
                          wr_hit[rd_num[gi]]  ? wr_data[rd_num[gi]] :
                                                regs_q[rd_num[gi]];
      assign bus.o_rd_data[gi*XLEN +: XLEN] = rd_data_q[gi];
    end
  endgenerate

  // A register being written back this cycle is already available.
  assign eff_busy = busy_q & ~wr_hit;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      hazard = hazard | eff_busy[rd_num[k]];
    end
    if (bus.i_dst_valid) begin
      hazard = hazard | eff_busy[bus.i_dst_num];
    end
  end

  assign stall   = ~reset & ~bus.i_hold & ~bus.i_flush & hazard;
  assign reserve = bus.i_dst_valid & ~stall & ~bus.i_hold & ~bus.i_flush &
                   (bus.i_dst_num != '0);

  // Reservation is OR-ed in after the write-back clear, so a register that is
  // both reserved and written back this cycle ends up busy.
  always_comb begin
    if (bus.i_flush) begin
      busy_d = '0;
    end else begin
      busy_d = eff_busy;
      if (reserve) begin
        busy_d = busy_d | (NREG'(1) << bus.i_dst_num);
      end
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_cnt_d = busy_cnt_d + {{RW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= ((r == SP_IDX) && (r != 0)) ? bus.i_stackptr : '0;
      end
      for (int k = 0; k < NRD; k++) begin
        rd_data_q[k] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_data[r];
        end
      end
      // Operands are captured every cycle, stalled or not.
      for (int k = 0; k < NRD; k++) begin
        rd_data_q[k] <= rd_val[k];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.o_stall    = stall;
  assign bus.o_busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_sb_regfile.sv
// tb_sb_regfile
//   Directed-vector bench for sb_regfile with hand-computed expectations.
module tb_sb_regfile;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWB  = 2;
  localparam int RW   = 5;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  sb_regfile_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWB(NWB)) bus ();

  sb_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWB(NWB), .SP_IDX(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_rd_num    = '0;
    bus.i_dst_num   = '0;
    bus.i_dst_valid = 1'b0;
    bus.i_hold      = 1'b0;
    bus.i_flush     = 1'b0;
    bus.i_wb_valid  = '0;
    bus.i_wb_num    = '0;
    bus.i_wb_data   = '0;
  endtask

  task automatic set_rd(input logic [RW-1:0] p0, input logic [RW-1:0] p1);
    bus.i_rd_num = {p1, p0};
  endtask

  task automatic set_dst(input logic v, input logic [RW-1:0] n);
    bus.i_dst_valid = v;
    bus.i_dst_num   = n;
  endtask

  task automatic set_wb(input logic v0, input logic [RW-1:0] n0, input logic [63:0] d0,
                        input logic v1, input logic [RW-1:0] n1, input logic [63:0] d1);
    bus.i_wb_valid = {v1, v0};
    bus.i_wb_num   = {n1, n0};
    bus.i_wb_data  = {d1, d0};
  endtask

  function automatic logic [63:0] rd0();
    return bus.o_rd_data[63:0];
  endfunction

  function automatic logic [63:0] rd1();
    return bus.o_rd_data[127:64];
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    idle();
    bus.i_stackptr = 64'h8000;
    reset = 1'b1;
    set_rd(5'd2, 5'd5);
    step();
    step();
    chk("reset_rd0", rd0(), 64'h0);
    chk("reset_cnt", 64'(bus.o_busy_cnt), 64'h0);
    chk("reset_stall", 64'(bus.o_stall), 64'h0);

    // Reset contents: r2 holds the stack pointer, r5 is zero.
    reset = 1'b0;
    step();
    chk("sp_r2", rd0(), 64'h8000);
    chk("sp_r5", rd1(), 64'h0);
    chk("sp_cnt", 64'(bus.o_busy_cnt), 64'h0);

    // RAW on r5, resolved by a write-back in the same cycle.
    idle();
    set_dst(1'b1, 5'd5);
    #1 chk("raw_issue_stall", 64'(bus.o_stall), 64'h0);
    step();
    chk("raw_cnt1", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    set_rd(5'd5, 5'd0);
    #1 chk("raw_stall", 64'(bus.o_stall), 64'h1);
    step();
    chk("raw_stall_hold", 64'(bus.o_stall), 64'h1);
    set_wb(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
    #1 chk("raw_wb_stall", 64'(bus.o_stall), 64'h0);
    step();
    chk("raw_bypass", rd0(), 64'h1234);
    chk("raw_cnt0", 64'(bus.o_busy_cnt), 64'h0);
    set_wb(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    step();
    chk("raw_array", rd0(), 64'h1234);

    // Two ports writing r7: port 1 wins, busy cleared.
    idle();
    set_dst(1'b1, 5'd7);
    step();
    chk("dual_cnt1", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    set_rd(5'd7, 5'd7);
    set_wb(1'b1, 5'd7, 64'hAA, 1'b1, 5'd7, 64'hBB);
    step();
    chk("dual_bypass", rd1(), 64'hBB);
    chk("dual_cnt0", 64'(bus.o_busy_cnt), 64'h0);
    set_wb(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    step();
    chk("dual_array", rd0(), 64'hBB);

    // Hold suppresses stall and reservation.
    idle();
    set_dst(1'b1, 5'd3);
    step();
    chk("hold_cnt1", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    bus.i_hold = 1'b1;
    set_rd(5'd3, 5'd0);
    set_dst(1'b1, 5'd9);
    #1 chk("hold_stall", 64'(bus.o_stall), 64'h0);
    step();
    chk("hold_cnt", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    set_rd(5'd3, 5'd0);
    #1 chk("hold_release_stall", 64'(bus.o_stall), 64'h1);
    set_wb(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33);
    step();
    chk("hold_clear_cnt", 64'(bus.o_busy_cnt), 64'h0);
    chk("hold_wb1_data", rd0(), 64'h33);

    // Flush drops all reservations.
    idle();
    set_dst(1'b1, 5'd4);
    step();
    set_dst(1'b1, 5'd6);
    step();
    chk("flush_cnt2", 64'(bus.o_busy_cnt), 64'h2);
    idle();
    bus.i_flush = 1'b1;
    set_dst(1'b1, 5'd12);
    step();
    chk("flush_cnt0", 64'(bus.o_busy_cnt), 64'h0);
    idle();
    set_rd(5'd4, 5'd6);
    #1 chk("flush_stall", 64'(bus.o_stall), 64'h0);

    // Reserve and write back the same register: it stays busy.
    idle();
    set_dst(1'b1, 5'd10);
    set_wb(1'b1, 5'd10, 64'h10, 1'b0, 5'd0, 64'h0);
    #1 chk("prio_stall", 64'(bus.o_stall), 64'h0);
    step();
    chk("prio_cnt", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    set_rd(5'd0, 5'd10);
    #1 chk("prio_busy_stall", 64'(bus.o_stall), 64'h1);
    bus.i_flush = 1'b1;
    step();

    // WAW: destination already busy stalls decode.
    idle();
    set_dst(1'b1, 5'd11);
    step();
    #1 chk("waw_issue_stall", 64'(bus.o_stall), 64'h1);
    step();
    chk("waw_cnt", 64'(bus.o_busy_cnt), 64'h1);

    // r0 ignores writes and reservations.
    idle();
    set_rd(5'd0, 5'd0);
    set_dst(1'b1, 5'd0);
    set_wb(1'b1, 5'd0, 64'hFF, 1'b0, 5'd0, 64'h0);
    #1 chk("r0_stall", 64'(bus.o_stall), 64'h0);
    step();
    chk("r0_bypass", rd0(), 64'h0);
    chk("r0_cnt", 64'(bus.o_busy_cnt), 64'h1);
    idle();
    step();
    chk("r0_array", rd0(), 64'h0);

    // Reset mid-operation beats write-back and reservation.
    bus.i_stackptr = 64'h4444;
    reset = 1'b1;
    set_dst(1'b1, 5'd9);
    set_wb(1'b1, 5'd2, 64'h99, 1'b1, 5'd7, 64'h77);
    #1 chk("mid_reset_stall", 64'(bus.o_stall), 64'h0);
    step();
    reset = 1'b0;
    idle();
    set_rd(5'd2, 5'd7);
    step();
    chk("mid_reset_sp", rd0(), 64'h4444);
    chk("mid_reset_r7", rd1(), 64'h0);
    chk("mid_reset_cnt", 64'(bus.o_busy_cnt), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sb_regfile.md
# sb_regfile

Parametrised integer register file with an integrated busy scoreboard, multiple read ports and multiple write-back ports. It sits between decode and execute. Decode presents source and destination register numbers. The block returns registered operand data one cycle later and raises a combinational stall on RAW or WAW hazards. Write-back ports write the array, clear busy bits and bypass into same-cycle reads. A flush input discards all in-flight reservations after a branch redirect.

## Interface
- XLEN, 64: register data width.
- NREG, 32: number of architectural registers, a power of two ≥ 4. RW = $clog2(NREG).
- NRD, 2: number of read ports.
- NWB, 2: number of write-back ports.
- SP_IDX, 2: index of the register loaded from i_stackptr at reset.
- clk  in  1  single clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high.
- i_rd_num  in  NRD*RW  source register numbers; port k occupies bits [k*RW +: RW].
- i_dst_num  in  RW  destination register to reserve.
- i_dst_valid  in  1  instruction in decode writes i_dst_num.
- i_hold  in  1  external stall (ld/st, branch); suppresses hazard stall and reservation.
- i_flush  in  1  clear every busy bit.
- i_wb_valid  in  NWB  per-port write enable.
- i_wb_num  in  NWB*RW  per-port destination.
- i_wb_data  in  NWB*XLEN  per-port data.
- i_stackptr  in  XLEN  reset value for register SP_IDX.
- o_rd_data  out  NRD*XLEN  registered operand data.
- o_stall  out  1  combinational hazard stall to decode.
- o_busy_cnt  out  RW+1  registered count of busy registers.

## Operation
- Register 0: always reads 0, is never busy, and ignores writes and reservations.
- Effective write: a WB port with valid=1 and num≠0. If several ports target the same register, the highest-index port wins, for data and for the bypass.
- Read value per port: 0 for r0. Otherwise the effective-write data of the winning WB port if one targets that register this cycle. Otherwise the array value.
- Effective busy(r): busy[r] & ~(an effective write to r this cycle).
- o_stall = ~i_hold & ~i_flush & (any effective busy(i_rd_num[k]) | (i_dst_valid & effective busy(i_dst_num))).
- Reserve: when i_dst_valid & ~o_stall & ~i_hold & ~i_flush & i_dst_num≠0, set busy[i_dst_num].
- Clear: every effective write clears busy[num].
- Priority on the same register in the same cycle: i_flush > reserve > clear. A reservation of a register being written back this cycle leaves it busy.
- i_flush clears all busy bits. WB writes in the same cycle still update the array.
- o_busy_cnt is the population count of the next busy vector, registered.

## Timing
- Reset: all array entries 0 except entry SP_IDX = i_stackptr; all busy bits 0; o_rd_data 0; o_busy_cnt 0. o_stall is 0 while reset is high.
- Read latency: 1 cycle. o_rd_data updates every non-reset cycle, including stalled cycles, from the bypassed read value.
- Write latency: data is visible in the array the cycle after the WB cycle. It is visible through the bypass in the same cycle.
- Hazard detection is combinational within the decode cycle. A stalled instruction re-evaluates each cycle with no extra latency once busy clears.
- Reset asserted mid-operation overrides every write, reservation and flush that cycle.

## Test plan
- Reset with i_stackptr=0x8000: next cycle, read r2 -> 0x8000 and r5 -> 0; o_busy_cnt=0.
- Issue dst=r5; next cycle read r5 -> o_stall=1. WB0 writes r5=0x1234 in a cycle with the read still pending -> o_stall=0 that cycle, and o_rd_data=0x1234 the following cycle.
- WB0 and WB1 both write r7 (0xAA, 0xBB) in one cycle -> r7 reads 0xBB; busy[7] clear.
- Reserve r3, then i_hold=1 with a source of r3 -> o_stall=0 and no new reservation; o_busy_cnt stays 1.
- Reserve r4 and r6, then i_flush=1 -> o_busy_cnt=0 next cycle; reads of r4 and r6 no longer stall.
- Write r0=0xFF and reserve dst=r0 -> r0 reads 0, o_stall=0, o_busy_cnt unchanged.
